wb_stage: RTL

Writeback stage of the five-stage pipeline. Accepts retiring instructions from MEM over a valid/ready handshake and waits for the data-memory load response when needed. It sign/zero-extends load data by funct3 and byte offset, then drives the register-file write port (RegWrite, rd, Write_data) that ID consumes. It also stalls upstream while a load is outstanding and keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM results, formats load data and drives
// the register-file write port, with a load-wait stall and retire counter.
module wb_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_RegWrite,
   input  logic              in_MemtoReg,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [2:0]        in_funct3,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              RegWrite_out,
   output logic [REG_AW-1:0] rd_out,
   output logic [XLEN-1:0]   Write_data,
   output logic              stall_out,
   output logic [XLEN-1:0]   instret
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              w_ready;
   logic              w_stall;
   logic              w_xfer;
   logic              w_xfer_alu;
   logic              w_xfer_ld;
   logic              w_ld_done;
   logic              w_retire;

   logic              r_ld_we;
   logic [REG_AW-1:0] r_ld_rd;
   logic [2:0]        r_ld_f3;
   logic [1:0]        r_ld_off;

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_ld_fmt;

   logic              w_wr_en;
   logic [REG_AW-1:0] w_wr_rd;
   logic [XLEN-1:0]   w_wr_data;

   logic              r_we;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_data;
   logic [XLEN-1:0]   r_instret;

   assign w_xfer     = in_valid && w_ready;
   assign w_xfer_alu = w_xfer && !in_MemtoReg;
   assign w_xfer_ld  = w_xfer && in_MemtoReg;
   assign w_ld_done  = (r_state == S_WAIT) && mem_rvalid;
   assign w_retire   = w_xfer_alu || w_ld_done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_xfer_ld)  w_state_nxt = S_WAIT;
         S_WAIT: if (mem_rvalid) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // Decoded from state only so MEM never sees a path from in_valid.
   always_comb begin
      w_ready = 1'b0;
      w_stall = 1'b0;
      unique case (r_state)
         S_IDLE:  w_ready = rst;
         S_WAIT:  w_stall = 1'b1;
         default: w_ready = 1'b0;
      endcase
   end

   assign in_ready  = w_ready;
   assign stall_out = w_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ld_we  <= 1'b0;
         r_ld_rd  <= '0;
         r_ld_f3  <= 3'b000;
         r_ld_off <= 2'b00;
      end else if (w_xfer_ld) begin
         r_ld_we  <= in_RegWrite;
         r_ld_rd  <= in_rd;
         r_ld_f3  <= in_funct3;
         r_ld_off <= in_alu_result[1:0];
      end
   end

   // Halfword select ignores off[0]; misaligned LH is not trapped here.
   always_comb begin
      w_byte = mem_rdata[{r_ld_off, 3'b000} +: 8];
      w_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_ld_fmt = mem_rdata;
      unique case (r_ld_f3)
         3'b000:  w_ld_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_byte};
         3'b001:  w_ld_fmt = {{(XLEN-16){w_half[15]}}, w_half};
         3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_half};
         default: w_ld_fmt = mem_rdata;
      endcase
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_rd   = r_rd;
      w_wr_data = r_data;
      unique case (1'b1)
         w_xfer_alu: begin
            w_wr_en   = in_RegWrite && (in_rd != '0);
            w_wr_rd   = in_rd;
            w_wr_data = in_alu_result;
         end
         w_ld_done: begin
            w_wr_en   = r_ld_we && (r_ld_rd != '0);
            w_wr_rd   = r_ld_rd;
            w_wr_data = w_ld_fmt;
         end
         default: begin
            w_wr_en   = 1'b0;
            w_wr_rd   = r_rd;
            w_wr_data = r_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_we      <= 1'b0;
         r_rd      <= '0;
         r_data    <= '0;
         r_instret <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_retire) begin
            r_we      <= w_wr_en;
            r_rd      <= w_wr_rd;
            r_data    <= w_wr_data;
            r_instret <= r_instret + XLEN'(1);
         end
      end
   end

   assign RegWrite_out = r_we;
   assign rd_out       = r_rd;
   assign Write_data   = r_data;
   assign instret      = r_instret;

endmodule
